// File: rtl/obi_to_tcdm_pkg.sv
// Shared types for the OBI-to-TCDM bridge: credit width helper, AMO encoding,
// the {rid, err} tag entry macro and default-width OBI/TCDM structs.
`define OBI_TCDM_TAG_T(tag_t, IdW) typedef struct packed { logic [(IdW)-1:0] rid; logic err; } tag_t;

package obi_to_tcdm_pkg;

  typedef enum logic [3:0] {
    AMONone = 4'h0, AMOSwap, AMOAdd, AMOAnd, AMOOr, AMOXor,
    AMOMax, AMOMaxu, AMOMin, AMOMinu, AMOLR, AMOSC
  } amo_e;

  // Width able to hold every value 0..depth.
  function automatic int cw(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DefAddrWidth = 32;
  localparam int DefDataWidth = 32;
  localparam int DefIdWidth   = 1;

  typedef struct packed {
    logic [DefAddrWidth-1:0]   addr;
    logic                      we;
    logic [DefDataWidth/8-1:0] be;
    logic [DefDataWidth-1:0]   wdata;
    logic [DefIdWidth-1:0]     aid;
  } obi_a_def_t;

  typedef struct packed {
    logic       req;
    obi_a_def_t a;
    logic       rready;
  } obi_req_def_t;

  typedef struct packed {
    logic [DefDataWidth-1:0] rdata;
    logic [DefIdWidth-1:0]   rid;
    logic                    err;
    logic                    r_optional;
  } obi_r_def_t;

  typedef struct packed {
    logic       gnt;
    logic       rvalid;
    obi_r_def_t r;
  } obi_rsp_def_t;

  typedef struct packed {
    logic [DefAddrWidth-1:0]   addr;
    logic                      write;
    amo_e                      amo;
    logic [DefDataWidth-1:0]   data;
    logic [DefDataWidth/8-1:0] strb;
    logic                      user;
  } tcdm_q_def_t;

  typedef struct packed {
    logic        q_valid;
    tcdm_q_def_t q;
  } tcdm_req_def_t;

  typedef struct packed {
    logic [DefDataWidth-1:0] data;
  } tcdm_p_def_t;

  typedef struct packed {
    logic        q_ready;
    logic        p_valid;
    tcdm_p_def_t p;
  } tcdm_rsp_def_t;

endpackage

// File: rtl/obi_to_tcdm_chan.sv
// One bridge channel: window check, credit counter, in-order tag FIFO and a
// fall-through data FIFO so a 1-cycle TCDM reply becomes rvalid immediately.
module obi_to_tcdm_chan
  import obi_to_tcdm_pkg::*;
#(
  parameter type obi_req_t  = obi_req_def_t,
  parameter type obi_rsp_t  = obi_rsp_def_t,
  parameter type tcdm_req_t = tcdm_req_def_t,
  parameter type tcdm_rsp_t = tcdm_rsp_def_t,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 1,
  parameter int unsigned BufDepth  = 2,
  parameter logic [AddrWidth-1:0] BaseAddr = '0,
  parameter longint unsigned WindowSize = 64'd1 << AddrWidth
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  obi_req_i,
  output obi_rsp_t  obi_rsp_o,
  output tcdm_req_t tcdm_req_o,
  input  tcdm_rsp_t tcdm_rsp_i
);

  localparam int CntW = cw(BufDepth);
  localparam int PtrW = (BufDepth > 1) ? $clog2(BufDepth) : 1;
  localparam logic [CntW-1:0] Depth = CntW'(BufDepth);

  `OBI_TCDM_TAG_T(tag_t, IdWidth)

  logic [CntW-1:0]      cnt_reg, cnt_next, data_cnt_reg;
  logic [PtrW-1:0]      tag_wr_reg, tag_rd_reg, data_wr_reg, data_rd_reg;
  tag_t                 tag_mem [BufDepth];
  logic [DataWidth-1:0] data_mem [BufDepth];
  logic                 rst_q_reg;

  logic [AddrWidth-1:0] offs;
  logic                 in_win, space, grant, rvalid, pop;
  logic                 data_push, data_pop, data_empty, store_push, store_pop;
  tag_t                 tag_head, tag_push;
  logic [DataWidth-1:0] data_head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(BufDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Unsigned offset wraps for addresses below BaseAddr, so one compare covers both ends.
  assign offs   = obi_req_i.a.addr - BaseAddr;
  assign in_win = (WindowSize == 64'd0) || (64'(offs) < WindowSize);
  assign space  = cnt_reg < Depth;
  assign grant  = ~rst_i & obi_req_i.req & space & (~in_win | tcdm_rsp_i.q_ready);

  assign tag_push   = '{rid: obi_req_i.a.aid, err: ~in_win};
  assign tag_head   = tag_mem[tag_rd_reg];
  assign data_push  = tcdm_rsp_i.p_valid & ~rst_q_reg;
  assign data_empty = (data_cnt_reg == '0);
  assign data_head  = data_empty ? tcdm_rsp_i.p.data : data_mem[data_rd_reg];

  assign rvalid   = ~rst_i & (cnt_reg != '0) & (tag_head.err | ~data_empty | data_push);
  assign pop      = rvalid & obi_req_i.rready;
  assign data_pop = pop & ~tag_head.err;

  // A reply consumed in its arrival cycle bypasses storage entirely.
  assign store_push = data_push & ~(data_pop & data_empty);
  assign store_pop  = data_pop & ~data_empty;

  always_comb begin
    tcdm_req_o         = '0;
    tcdm_req_o.q_valid = ~rst_i & obi_req_i.req & in_win & space;
    tcdm_req_o.q.addr  = obi_req_i.a.addr;
    tcdm_req_o.q.write = obi_req_i.a.we;
    tcdm_req_o.q.amo   = AMONone;
    tcdm_req_o.q.data  = obi_req_i.a.wdata;
    tcdm_req_o.q.strb  = obi_req_i.a.be;
    tcdm_req_o.q.user  = '0;

    obi_rsp_o              = '0;
    obi_rsp_o.gnt          = grant;
    obi_rsp_o.rvalid       = rvalid;
    obi_rsp_o.r.rdata      = tag_head.err ? '0 : data_head;
    obi_rsp_o.r.rid        = tag_head.rid;
    obi_rsp_o.r.err        = tag_head.err;
    obi_rsp_o.r.r_optional = '0;
  end

  always_comb begin
    cnt_next = cnt_reg;
    case ({grant, pop})
      2'b10:   cnt_next = cnt_reg + 1'b1;
      2'b01:   cnt_next = cnt_reg - 1'b1;
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg      <= '0;
      data_cnt_reg <= '0;
      tag_wr_reg   <= '0;
      tag_rd_reg   <= '0;
      data_wr_reg  <= '0;
      data_rd_reg  <= '0;
    end else begin
      cnt_reg <= cnt_next;
      if (grant)      tag_wr_reg  <= ptr_inc(tag_wr_reg);
      if (pop)        tag_rd_reg  <= ptr_inc(tag_rd_reg);
      if (store_push) data_wr_reg <= ptr_inc(data_wr_reg);
      if (store_pop)  data_rd_reg <= ptr_inc(data_rd_reg);
      if (store_push && !store_pop)      data_cnt_reg <= data_cnt_reg + 1'b1;
      else if (store_pop && !store_push) data_cnt_reg <= data_cnt_reg - 1'b1;
    end
  end

  // Storage arrays carry no reset; the pointers alone define validity.
  always_ff @(posedge clk_i) begin
    rst_q_reg <= rst_i;
    if (grant)      tag_mem[tag_wr_reg]   <= tag_push;
    if (store_push) data_mem[data_wr_reg] <= tcdm_rsp_i.p.data;
  end

`ifndef SYNTHESIS
  a_no_data_overflow: assert property (@(posedge clk_i) disable iff (rst_i || rst_q_reg)
    !(data_push && (data_cnt_reg == Depth)));
`endif

endmodule

// File: rtl/obi_to_tcdm_buffered.sv
// Multi-channel OBI-to-TCDM bridge; every channel is an independent instance.
module obi_to_tcdm_buffered
  import obi_to_tcdm_pkg::*;
#(
  parameter type obi_req_t  = obi_req_def_t,
  parameter type obi_rsp_t  = obi_rsp_def_t,
  parameter type tcdm_req_t = tcdm_req_def_t,
  parameter type tcdm_rsp_t = tcdm_rsp_def_t,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned IdWidth     = 1,
  parameter int unsigned BufDepth    = 2,
  parameter int unsigned NumChannels = 1,
  parameter logic [AddrWidth-1:0] BaseAddr = '0,
  parameter longint unsigned WindowSize = 64'd1 << AddrWidth
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  obi_req_i  [NumChannels],
  output obi_rsp_t  obi_rsp_o  [NumChannels],
  output tcdm_req_t tcdm_req_o [NumChannels],
  input  tcdm_rsp_t tcdm_rsp_i [NumChannels]
);

  for (genvar gi = 0; gi < NumChannels; gi++) begin : g_chan
    obi_to_tcdm_chan #(
      .obi_req_t  (obi_req_t),
      .obi_rsp_t  (obi_rsp_t),
      .tcdm_req_t (tcdm_req_t),
      .tcdm_rsp_t (tcdm_rsp_t),
      .AddrWidth  (AddrWidth),
      .DataWidth  (DataWidth),
      .IdWidth    (IdWidth),
      .BufDepth   (BufDepth),
      .BaseAddr   (BaseAddr),
      .WindowSize (WindowSize)
    ) i_chan (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .obi_req_i  (obi_req_i[gi]),
      .obi_rsp_o  (obi_rsp_o[gi]),
      .tcdm_req_o (tcdm_req_o[gi]),
      .tcdm_rsp_i (tcdm_rsp_i[gi])
    );
  end

endmodule

// File: tb/tb_obi_to_tcdm_buffered.sv
// Directed bench: two channels, BufDepth 2, window 0x1000..0x1FFF, 1-cycle TCDM model.
module tb_obi_to_tcdm_buffered;
  import obi_to_tcdm_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  obi_req_def_t  obi_req  [2];
  obi_rsp_def_t  obi_rsp  [2];
  tcdm_req_def_t tcdm_req [2];
  tcdm_rsp_def_t tcdm_rsp [2];

  logic        qr [2];
  logic        pv [2];
  logic [31:0] pd [2];
  logic [31:0] mem [16];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  obi_to_tcdm_buffered #(
    .NumChannels (2),
    .BufDepth    (2),
    .BaseAddr    (32'h1000),
    .WindowSize  (64'h1000)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .obi_req_i  (obi_req),
    .obi_rsp_o  (obi_rsp),
    .tcdm_req_o (tcdm_req),
    .tcdm_rsp_i (tcdm_rsp)
  );

  // TCDM model: answers every accepted request exactly one cycle later.
  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      pv[c] <= tcdm_req[c].q_valid & qr[c];
      pd[c] <= mem[tcdm_req[c].q.addr[5:2]];
      if (tcdm_req[c].q_valid && qr[c] && tcdm_req[c].q.write)
        mem[tcdm_req[c].q.addr[5:2]] <= tcdm_req[c].q.data;
    end
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      tcdm_rsp[c]         = '0;
      tcdm_rsp[c].q_ready = qr[c];
      tcdm_rsp[c].p_valid = pv[c];
      tcdm_rsp[c].p.data  = pd[c];
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int ch, input logic req, input logic [31:0] addr,
                         input logic we, input logic aid, input logic [31:0] wdata);
    obi_req[ch].req     = req;
    obi_req[ch].a.addr  = addr;
    obi_req[ch].a.we    = we;
    obi_req[ch].a.be    = 4'hF;
    obi_req[ch].a.wdata = wdata;
    obi_req[ch].a.aid   = aid;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    qr[0] = 1'b1; qr[1] = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0]  = 32'hDEADBEEF;
    mem[1]  = 32'h11111111;
    mem[2]  = 32'h22222222;
    mem[3]  = 32'h33333333;
    mem[15] = 32'hF0F0F0F0;
    for (int c = 0; c < 2; c++) begin
      obi_req[c] = '0;
    end

    // Reset: gnt/q_valid/rvalid gated even with a live request.
    tick(); set_req(0, 1, 32'h1100, 0, 1, 0); #1;
    chk("rst_gnt", obi_rsp[0].gnt, 0);
    chk("rst_qvalid", tcdm_req[0].q_valid, 0);
    chk("rst_rvalid0", obi_rsp[0].rvalid, 0);
    chk("rst_rvalid1", obi_rsp[1].rvalid, 0);
    tick(); rst = 1'b0; set_req(0, 0, 0, 0, 0, 0);

    // Single read.
    tick(); set_req(0, 1, 32'h1100, 0, 1, 0); #1;
    chk("rd_qvalid", tcdm_req[0].q_valid, 1);
    chk("rd_write", tcdm_req[0].q.write, 0);
    chk("rd_addr", tcdm_req[0].q.addr, 32'h1100);
    chk("rd_gnt", obi_rsp[0].gnt, 1);
    chk("rd_rvalid_early", obi_rsp[0].rvalid, 0);
    tick(); set_req(0, 0, 0, 0, 0, 0); obi_req[0].rready = 1'b1; #1;
    chk("rd_rvalid", obi_rsp[0].rvalid, 1);
    chk("rd_rdata", obi_rsp[0].r.rdata, 32'hDEADBEEF);
    chk("rd_rid", obi_rsp[0].r.rid, 1);
    chk("rd_err", obi_rsp[0].r.err, 0);
    tick(); obi_req[0].rready = 1'b0; #1;
    chk("rd_done", obi_rsp[0].rvalid, 0);

    // Back-to-back reads with rready low until credits run out.
    tick(); set_req(0, 1, 32'h1104, 0, 0, 0); #1;
    chk("b2b_gnt1", obi_rsp[0].gnt, 1);
    tick(); set_req(0, 1, 32'h1108, 0, 1, 0); #1;
    chk("b2b_gnt2", obi_rsp[0].gnt, 1);
    chk("b2b_head_rdata", obi_rsp[0].r.rdata, 32'h11111111);
    tick(); set_req(0, 1, 32'h110C, 0, 0, 0); #1;
    chk("b2b_full_gnt", obi_rsp[0].gnt, 0);
    chk("b2b_full_qvalid", tcdm_req[0].q_valid, 0);
    tick(); obi_req[0].rready = 1'b1; #1;
    chk("b2b_gnt_not_rready", obi_rsp[0].gnt, 0);
    chk("b2b_r1_rdata", obi_rsp[0].r.rdata, 32'h11111111);
    chk("b2b_r1_rid", obi_rsp[0].r.rid, 0);
    tick(); #1;
    chk("b2b_r2_rvalid", obi_rsp[0].rvalid, 1);
    chk("b2b_r2_rdata", obi_rsp[0].r.rdata, 32'h22222222);
    chk("b2b_r2_rid", obi_rsp[0].r.rid, 1);
    chk("b2b_gnt_after_pop", obi_rsp[0].gnt, 1);
    tick(); set_req(0, 0, 0, 0, 0, 0); #1;
    chk("b2b_r3_rvalid", obi_rsp[0].rvalid, 1);
    chk("b2b_r3_rdata", obi_rsp[0].r.rdata, 32'h33333333);
    tick(); #1;
    chk("b2b_drained", obi_rsp[0].rvalid, 0);

    // Out-of-window between in-window reads, plus window boundaries.
    tick(); set_req(0, 1, 32'h1100, 0, 0, 0); #1;
    chk("win_a_gnt", obi_rsp[0].gnt, 1);
    tick(); set_req(0, 1, 32'h3000, 0, 1, 0); #1;
    chk("win_oow_qvalid", tcdm_req[0].q_valid, 0);
    chk("win_oow_gnt", obi_rsp[0].gnt, 1);
    chk("win_a_rdata", obi_rsp[0].r.rdata, 32'hDEADBEEF);
    chk("win_a_err", obi_rsp[0].r.err, 0);
    tick(); set_req(0, 1, 32'h1104, 0, 0, 0); #1;
    chk("win_e_rvalid", obi_rsp[0].rvalid, 1);
    chk("win_e_err", obi_rsp[0].r.err, 1);
    chk("win_e_rdata", obi_rsp[0].r.rdata, 0);
    chk("win_e_rid", obi_rsp[0].r.rid, 1);
    tick(); set_req(0, 1, 32'h2000, 0, 0, 0); #1;
    chk("win_b_rdata", obi_rsp[0].r.rdata, 32'h11111111);
    chk("win_b_err", obi_rsp[0].r.err, 0);
    chk("win_top_qvalid", tcdm_req[0].q_valid, 0);
    tick(); set_req(0, 1, 32'h1FFC, 0, 1, 0); #1;
    chk("win_last_qvalid", tcdm_req[0].q_valid, 1);
    chk("win_top_err", obi_rsp[0].r.err, 1);
    tick(); set_req(0, 1, 32'h0FFC, 0, 0, 0); #1;
    chk("win_below_qvalid", tcdm_req[0].q_valid, 0);
    chk("win_last_rdata", obi_rsp[0].r.rdata, 32'hF0F0F0F0);
    chk("win_last_rid", obi_rsp[0].r.rid, 1);

    // Write.
    tick(); set_req(0, 1, 32'h1108, 1, 1, 32'h12345678); #1;
    chk("win_below_err", obi_rsp[0].r.err, 1);
    chk("wr_write", tcdm_req[0].q.write, 1);
    chk("wr_strb", tcdm_req[0].q.strb, 4'hF);
    chk("wr_data", tcdm_req[0].q.data, 32'h12345678);
    chk("wr_amo", tcdm_req[0].q.amo, AMONone);
    chk("wr_gnt", obi_rsp[0].gnt, 1);
    tick(); set_req(0, 0, 0, 0, 0, 0); #1;
    chk("wr_rvalid", obi_rsp[0].rvalid, 1);
    chk("wr_err", obi_rsp[0].r.err, 0);
    chk("wr_rid", obi_rsp[0].r.rid, 1);
    tick(); obi_req[0].rready = 1'b0; #1;
    chk("wr_done", obi_rsp[0].rvalid, 0);

    // TCDM stall for three cycles.
    tick(); qr[0] = 1'b0; set_req(0, 1, 32'h1108, 0, 0, 0); #1;
    chk("stall_qvalid", tcdm_req[0].q_valid, 1);
    chk("stall_gnt1", obi_rsp[0].gnt, 0);
    tick(); #1;
    chk("stall_gnt2", obi_rsp[0].gnt, 0);
    chk("stall_rvalid2", obi_rsp[0].rvalid, 0);
    tick(); #1;
    chk("stall_gnt3", obi_rsp[0].gnt, 0);
    tick(); qr[0] = 1'b1; #1;
    chk("stall_release_gnt", obi_rsp[0].gnt, 1);
    tick(); set_req(0, 0, 0, 0, 0, 0); obi_req[0].rready = 1'b1; #1;
    chk("stall_rdata", obi_rsp[0].r.rdata, 32'h12345678);
    chk("stall_rid", obi_rsp[0].r.rid, 0);
    tick(); obi_req[0].rready = 1'b0; #1;
    chk("stall_done", obi_rsp[0].rvalid, 0);

    // Reset with two outstanding.
    tick(); set_req(0, 1, 32'h1100, 0, 0, 0); #1;
    chk("rs_gnt1", obi_rsp[0].gnt, 1);
    tick(); set_req(0, 1, 32'h1104, 0, 1, 0); #1;
    chk("rs_gnt2", obi_rsp[0].gnt, 1);
    tick(); set_req(0, 0, 0, 0, 0, 0); rst = 1'b1; #1;
    chk("rs_in_rvalid", obi_rsp[0].rvalid, 0);
    tick(); rst = 1'b0; #1;
    chk("rs_after_rvalid", obi_rsp[0].rvalid, 0);
    tick(); set_req(0, 1, 32'h1100, 0, 1, 0); #1;
    chk("rs_new_gnt1", obi_rsp[0].gnt, 1);
    tick(); set_req(0, 1, 32'h1104, 0, 0, 0); #1;
    chk("rs_new_gnt2", obi_rsp[0].gnt, 1);
    chk("rs_new_rid", obi_rsp[0].r.rid, 1);
    tick(); set_req(0, 1, 32'h1108, 0, 0, 0); #1;
    chk("rs_new_full", obi_rsp[0].gnt, 0);
    tick(); set_req(0, 0, 0, 0, 0, 0); obi_req[0].rready = 1'b1; #1;
    chk("rs_new_r1", obi_rsp[0].r.rdata, 32'hDEADBEEF);
    tick(); #1;
    chk("rs_new_r2", obi_rsp[0].r.rdata, 32'h11111111);
    chk("rs_new_r2_rid", obi_rsp[0].r.rid, 0);
    tick(); obi_req[0].rready = 1'b0; #1;
    chk("rs_new_done", obi_rsp[0].rvalid, 0);

    // Two channels concurrently.
    tick();
    set_req(0, 1, 32'h1100, 0, 1, 0);
    set_req(1, 1, 32'h3000, 0, 0, 0);
    obi_req[0].rready = 1'b1; obi_req[1].rready = 1'b1; #1;
    chk("mc_gnt0", obi_rsp[0].gnt, 1);
    chk("mc_qv0", tcdm_req[0].q_valid, 1);
    chk("mc_gnt1", obi_rsp[1].gnt, 1);
    chk("mc_qv1", tcdm_req[1].q_valid, 0);
    tick(); set_req(0, 0, 0, 0, 0, 0); set_req(1, 1, 32'h1104, 0, 1, 0); #1;
    chk("mc_rdata0", obi_rsp[0].r.rdata, 32'hDEADBEEF);
    chk("mc_rid0", obi_rsp[0].r.rid, 1);
    chk("mc_err1", obi_rsp[1].r.err, 1);
    chk("mc_rid1", obi_rsp[1].r.rid, 0);
    chk("mc_qv1b", tcdm_req[1].q_valid, 1);
    tick(); set_req(1, 0, 0, 0, 0, 0); #1;
    chk("mc_rdata1", obi_rsp[1].r.rdata, 32'h11111111);
    chk("mc_rid1b", obi_rsp[1].r.rid, 1);
    chk("mc_idle0", obi_rsp[0].rvalid, 0);
    tick(); #1;
    chk("mc_done1", obi_rsp[1].rvalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
